// File: rtl/pu_conn_context_rdr_pkg.sv
// Shared types and constants for the connection-context burst reader:
// memory map constants, the context-memory command type and the reader FSM states.
package pu_conn_context_rdr_pkg;

  localparam int unsigned PuWidthNbits      = 32;
  localparam int unsigned RciNbits          = 6;
  localparam int unsigned SciNbits          = 6;
  localparam int unsigned ConnCtxDepthNbits = 4;
  localparam int unsigned PuMemAddrNbits    = 16;
  localparam int unsigned PuMemSelNbits     = 4;

  // Memory select lives in the top address bits.
  localparam logic [PuMemSelNbits-1:0] PuConnectionContextMem = 4'h3;

  typedef struct packed {
    logic                      wr;
    logic [PuMemAddrNbits-1:0] addr;
    logic [PuWidthNbits-1:0]   wdata;
  } io_type;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StErr
  } rdr_state_e;

  function automatic logic [PuMemAddrNbits-1:0] ctx_addr(
    input logic [RciNbits-1:0]          rci,
    input logic [ConnCtxDepthNbits-1:0] off
  );
    logic [PuMemAddrNbits-1:0] a;
    a = '0;
    a[PuMemAddrNbits-1 -: PuMemSelNbits]                    = PuConnectionContextMem;
    a[RciNbits+ConnCtxDepthNbits-1 : ConnCtxDepthNbits] = rci;
    a[ConnCtxDepthNbits-1:0]                                = off;
    return a;
  endfunction

endpackage

// File: rtl/pu_conn_context_rdr.sv
// Burst reader for one lane of the connection-context responder: issues one word read at a
// time, returns each word with a 1-cycle registered latency, and aborts on response timeout.
module pu_conn_context_rdr
  import pu_conn_context_rdr_pkg::*;
#(
  parameter int unsigned WIDTH_NBITS = PuWidthNbits,
  parameter int unsigned LEN_NBITS   = 4,
  parameter int unsigned TMO_NBITS   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rd_req_i,
  input  logic [RciNbits-1:0]          rd_rci_i,
  input  logic [ConnCtxDepthNbits-1:0] rd_offset_i,
  input  logic [LEN_NBITS-1:0]         rd_len_i,
  output logic                         rd_ready_o,
  output logic                         io_req_o,
  output io_type                       io_cmd_o,
  input  logic                         io_ack_i,
  input  logic [WIDTH_NBITS-1:0]       io_ack_data_i,
  output logic                         rd_valid_o,
  output logic [WIDTH_NBITS-1:0]       rd_data_o,
  output logic                         rd_last_o,
  output logic                         rd_err_o
);

  localparam logic [TMO_NBITS-1:0] TmoMax = '1;

  rdr_state_e                   state_q, state_d;
  logic [RciNbits-1:0]          rci_q, rci_d;
  logic [ConnCtxDepthNbits-1:0] offset_q, offset_d;
  logic [LEN_NBITS-1:0]         remaining_q, remaining_d;
  logic [TMO_NBITS-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                         rd_valid_q, rd_valid_d;
  logic                         rd_last_q, rd_last_d;
  logic [WIDTH_NBITS-1:0]       rd_data_q, rd_data_d;

  always_comb begin
    state_d     = state_q;
    rci_d       = rci_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    tmo_cnt_d   = tmo_cnt_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    rd_data_d   = rd_data_q;
    rd_ready_o  = 1'b0;
    io_req_o    = 1'b0;
    io_cmd_o    = '0;
    rd_err_o    = 1'b0;

    case (state_q)
      StIdle: begin
        // Holding off during the rd_last cycle makes the earliest back-to-back
        // accept land on the cycle after the final word.
        rd_ready_o = ~rd_last_q;
        if (rd_req_i && rd_ready_o) begin
          rci_d       = rd_rci_i;
          offset_d    = rd_offset_i;
          remaining_d = rd_len_i;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        io_req_o      = 1'b1;
        io_cmd_o.addr = ctx_addr(rci_q, offset_q);
        tmo_cnt_d     = '0;
        state_d       = StWait;
      end
      StWait: begin
        // An ack on the expiry cycle takes priority over the timeout.
        if (io_ack_i) begin
          rd_valid_d = 1'b1;
          rd_data_d  = io_ack_data_i;
          offset_d   = offset_q + 1'b1;
          if (remaining_q == '0) begin
            rd_last_d = 1'b1;
            state_d   = StIdle;
          end else begin
            remaining_d = remaining_q - 1'b1;
            state_d     = StIssue;
          end
        end else if (tmo_cnt_q == TmoMax) begin
          state_d = StErr;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StErr: begin
        rd_err_o = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rci_q       <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      tmo_cnt_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rci_q       <= rci_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_pu_conn_context_rdr.sv
// Directed self-checking bench for pu_conn_context_rdr (timeout counter shortened to 4 bits).
module tb_pu_conn_context_rdr;
  import pu_conn_context_rdr_pkg::*;

  logic                         clk_i = 1'b0;
  logic                         rst_ni;
  logic                         rd_req_i;
  logic [RciNbits-1:0]          rd_rci_i;
  logic [ConnCtxDepthNbits-1:0] rd_offset_i;
  logic [3:0]                   rd_len_i;
  logic                         rd_ready_o;
  logic                         io_req_o;
  io_type                       io_cmd_o;
  logic                         io_ack_i;
  logic [31:0]                  io_ack_data_i;
  logic                         rd_valid_o;
  logic [31:0]                  rd_data_o;
  logic                         rd_last_o;
  logic                         rd_err_o;

  int n_checks = 0;
  int n_errors = 0;

  pu_conn_context_rdr #(
    .WIDTH_NBITS(32),
    .LEN_NBITS  (4),
    .TMO_NBITS  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_req_i     (rd_req_i),
    .rd_rci_i     (rd_rci_i),
    .rd_offset_i  (rd_offset_i),
    .rd_len_i     (rd_len_i),
    .rd_ready_o   (rd_ready_o),
    .io_req_o     (io_req_o),
    .io_cmd_o     (io_cmd_o),
    .io_ack_i     (io_ack_i),
    .io_ack_data_i(io_ack_data_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .rd_last_o    (rd_last_o),
    .rd_err_o     (rd_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected command: read, memory select 0x3 in addr[15:12], rci in [9:4], offset in [3:0].
  function automatic logic [63:0] exp_cmd(input logic [5:0] rci, input logic [3:0] off);
    logic [15:0] a;
    a = {4'h3, 2'b00, rci, off};
    return {15'b0, 1'b0, a, 32'h0};
  endfunction

  // Accepts a burst from IDLE; returns in the ISSUE cycle.
  task automatic start_burst(input logic [5:0] rci, input logic [3:0] off, input logic [3:0] len);
    check("ready_before_req", rd_ready_o, 1);
    rd_rci_i    = rci;
    rd_offset_i = off;
    rd_len_i    = len;
    rd_req_i    = 1'b1;
    tick();
    rd_req_i    = 1'b0;
  endtask

  task automatic ack_word(input logic [31:0] data);
    io_ack_i      = 1'b1;
    io_ack_data_i = data;
    tick();
    io_ack_i      = 1'b0;
    io_ack_data_i = '0;
  endtask

  initial begin
    int waited;
    rst_ni        = 1'b0;
    rd_req_i      = 1'b0;
    rd_rci_i      = '0;
    rd_offset_i   = '0;
    rd_len_i      = '0;
    io_ack_i      = 1'b0;
    io_ack_data_i = '0;
    #12;
    check("rst_ready", rd_ready_o, 1);
    check("rst_io_req", io_req_o, 0);
    check("rst_io_cmd", io_cmd_o, 0);
    check("rst_outs", {rd_valid_o, rd_last_o, rd_err_o}, 0);
    check("rst_data", rd_data_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Single-word burst, ack four cycles into WAIT.
    start_burst(6'd5, 4'd3, 4'd0);
    check("s1_io_req", io_req_o, 1);
    check("s1_io_cmd", io_cmd_o, exp_cmd(6'd5, 4'd3));
    check("s1_ready_busy", rd_ready_o, 0);
    tick();
    check("s1_req_one_cycle", io_req_o, 0);
    check("s1_cmd_idle_zero", io_cmd_o, 0);
    repeat (3) tick();
    ack_word(32'hA5);
    check("s1_valid", rd_valid_o, 1);
    check("s1_last", rd_last_o, 1);
    check("s1_data", rd_data_o, 32'hA5);
    check("s1_ready_in_last", rd_ready_o, 0);
    tick();
    check("s1_valid_pulse", rd_valid_o, 0);
    check("s1_ready_after", rd_ready_o, 1);

    // Four-word burst wrapping the offset: 15, 0, 1, 2.
    start_burst(6'd9, 4'd15, 4'd3);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("s2_io_req_%0d", w), io_req_o, 1);
      check($sformatf("s2_io_cmd_%0d", w), io_cmd_o, exp_cmd(6'd9, 4'((15 + w) % 16)));
      tick();
      check($sformatf("s2_wait_noreq_%0d", w), io_req_o, 0);
      ack_word(32'h100 + 32'(w));
      check($sformatf("s2_valid_%0d", w), rd_valid_o, 1);
      check($sformatf("s2_data_%0d", w), rd_data_o, 32'h100 + 32'(w));
      check($sformatf("s2_last_%0d", w), rd_last_o, (w == 3) ? 1 : 0);
    end
    tick();

    // No ack: rd_err 16 cycles after entering WAIT, then a stray ack is dropped.
    start_burst(6'd1, 4'd0, 4'd0);
    tick();
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      waited++;
      if (rd_err_o) break;
    end
    check("s3_tmo_latency", waited, 16);
    check("s3_err", rd_err_o, 1);
    check("s3_no_last", {rd_valid_o, rd_last_o}, 0);
    tick();
    check("s3_err_pulse", rd_err_o, 0);
    check("s3_ready", rd_ready_o, 1);
    ack_word(32'hDEAD);
    check("s3_stray_ack", rd_valid_o, 0);
    check("s3_ready_after", rd_ready_o, 1);

    // Ack on the expiry cycle wins over the timeout.
    start_burst(6'd7, 4'd8, 4'd0);
    tick();
    repeat (15) tick();
    ack_word(32'h77);
    check("s4_valid", rd_valid_o, 1);
    check("s4_data", rd_data_o, 32'h77);
    check("s4_last", rd_last_o, 1);
    check("s4_no_err", rd_err_o, 0);
    tick();
    check("s4_no_err_after", rd_err_o, 0);
    tick();

    // Reset asserted in WAIT of a len=2 burst.
    start_burst(6'd2, 4'd4, 4'd2);
    tick();
    ack_word(32'h5A5A);
    check("s5_first_data", rd_data_o, 32'h5A5A);
    check("s5_reissue", io_req_o, 1);
    check("s5_reissue_cmd", io_cmd_o, exp_cmd(6'd2, 4'd5));
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    check("s5_rst_outs", {io_req_o, rd_valid_o, rd_last_o, rd_err_o}, 0);
    check("s5_rst_data", rd_data_o, 0);
    check("s5_rst_cmd", io_cmd_o, 0);
    check("s5_rst_ready", rd_ready_o, 1);
    tick();
    rst_ni = 1'b1;
    ack_word(32'hBEEF);
    check("s5_post_rst_ack", rd_valid_o, 0);
    check("s5_post_rst_req", io_req_o, 0);

    // rd_req held high: next burst accepted the cycle after rd_last.
    rd_rci_i    = 6'd3;
    rd_offset_i = 4'd7;
    rd_len_i    = 4'd0;
    rd_req_i    = 1'b1;
    tick();
    check("s6_io_req1", io_req_o, 1);
    tick();
    check("s6_wait_ignored", io_req_o, 0);
    ack_word(32'h11);
    rd_req_i = 1'b1;
    check("s6_last", rd_last_o, 1);
    check("s6_no_req_in_last", io_req_o, 0);
    check("s6_not_ready_in_last", rd_ready_o, 0);
    tick();
    check("s6_ready_next", rd_ready_o, 1);
    check("s6_no_req_yet", io_req_o, 0);
    tick();
    rd_req_i = 1'b0;
    check("s6_io_req2", io_req_o, 1);
    check("s6_io_cmd2", io_cmd_o, exp_cmd(6'd3, 4'd7));
    tick();
    ack_word(32'h22);
    check("s6_data2", rd_data_o, 32'h22);
    check("s6_last2", rd_last_o, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pu_conn_context_rdr.md
PU_CONN_CONTEXT_RDR -- requirements
Module: pu_conn_context_rdr

Interface
REQ-001 SHALL have parameter WIDTH_NBITS, default `PU_WIDTH_NBITS, the io_ack_data and rd_data width.
REQ-002 SHALL have parameter LEN_NBITS, default 4, the burst length field width.
REQ-003 SHALL have parameter TMO_NBITS, default 8, the timeout counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port `RESET_SIG, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port rd_req, input, 1, burst read request; accepted when rd_req&rd_ready.
REQ-007 SHALL have port rd_rci, input, `RCI_NBITS, the connection index.
REQ-008 SHALL have port rd_offset, input, `CONNECTION_CONTEXT_DEPTH_NBITS, the first word offset.
REQ-009 SHALL have port rd_len, input, LEN_NBITS, the word count minus 1.
REQ-010 SHALL have port rd_ready, output, 1, high only in IDLE.
REQ-011 SHALL have port io_req, output, 1, a one-cycle request pulse to the context memory.
REQ-012 SHALL have port io_cmd, output, io_type, the command; valid while io_req is high.
REQ-013 SHALL have port io_ack, input, 1, the response strobe.
REQ-014 SHALL have port io_ack_data, input, WIDTH_NBITS, the response data.
REQ-015 SHALL have port rd_valid, output, 1, a one-cycle strobe per returned word.
REQ-016 SHALL have port rd_data, output, WIDTH_NBITS, the returned word.
REQ-017 SHALL have port rd_last, output, 1, qualifies the final word of a burst.
REQ-018 SHALL have port rd_err, output, 1, a one-cycle timeout error pulse.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, ERR.
REQ-020 IDLE->ISSUE on accept; latch rci, offset, remaining=rd_len.
REQ-021 ISSUE: assert io_req for exactly one cycle, then go to WAIT.
REQ-022 io_cmd.addr[`PU_MEM_DEPTH_MSB_RANGE] SHALL be `PU_CONNECTION_CONTEXT_MEM.
REQ-023 io_cmd.addr[`RCI_NBITS-1+`CONNECTION_CONTEXT_DEPTH_NBITS:`CONNECTION_CONTEXT_DEPTH_NBITS] SHALL be the rci; addr[`CONNECTION_CONTEXT_DEPTH_NBITS-1:0] SHALL be the current offset; all other io_cmd fields SHALL be 0.
REQ-024 SHALL keep at most one request outstanding: no io_req from issue until io_ack or timeout, because the responder holds one entry per PU.
REQ-025 WAIT with io_ack: rd_valid=1 next cycle and rd_data=io_ack_data (registered, 1-cycle latency); offset+1 wraps modulo 2^`CONNECTION_CONTEXT_DEPTH_NBITS with rci unchanged; remaining==0 -> rd_last=1 with that word, go to IDLE; otherwise decrement and go to ISSUE.
REQ-026 WAIT counts cycles from 0; count==2^TMO_NBITS-1 without io_ack -> ERR.
REQ-027 io_ack in the same cycle as timeout expiry SHALL win, with no error.
REQ-028 ERR: rd_err=1 for one cycle, burst aborted with no rd_last, then go to IDLE.
REQ-029 io_ack in IDLE or ERR (late or stray) SHALL be dropped: no rd_valid.
REQ-030 rd_req outside IDLE SHALL be ignored.
REQ-031 A back-to-back burst SHALL be accepted in the cycle after rd_last at the earliest.

Reset
REQ-032 On reset assertion, state=IDLE and rd_ready=1.
REQ-033 On reset assertion, io_req, rd_valid, rd_last, rd_err, rd_data, io_cmd, counters and latches SHALL be 0.
REQ-034 Reset mid-burst SHALL abandon the burst; an io_ack after deassertion is dropped per REQ-029.

Structure
REQ-035 io_type, `PU_CONNECTION_CONTEXT_MEM, `PU_MEM_DEPTH_MSB_RANGE and the RCI/SCI/depth widths SHALL come from type_package / defines.vh; the state enum SHALL be added to type_package.
REQ-036 SHALL be a single module with no sub-modules; it connects to one io_req/io_cmd/io_ack lane of the connection-context responder.

Verification
REQ-037 Scenario: rci=5, offset=3, len=0, ack after 4 cycles with data 0xA5 -> one io_req with addr rci=5/off=3; rd_valid+rd_last with 0xA5 one cycle after ack.
REQ-038 Scenario: len=3, offset=max-1 -> four io_reqs at offsets max-1, 0, 1, 2, same rci; rd_last on the 4th word only.
REQ-039 Scenario: no ack, TMO_NBITS=4 -> rd_err 16 cycles after entering WAIT; later ack dropped; rd_ready=1.
REQ-040 Scenario: ack on the exact expiry cycle -> data delivered, rd_err=0.
REQ-041 Scenario: reset asserted in WAIT of a len=2 burst -> all outputs 0 immediately; post-reset ack gives no rd_valid.
REQ-042 Scenario: rd_req held high across a burst -> second burst accepted the cycle after rd_last; never two io_reqs without an intervening ack.
